// File: rtl/mux_pkg.sv
// Shared types, defaults and sizing helper for the round-robin stream mux.
package mux_pkg;

   localparam int N_DEF  = 32;
   localparam int CH_DEF = 4;
   localparam int SW_MAX = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

   typedef struct packed {
      logic              any;
      logic [SW_MAX-1:0] idx;
   } grant_t;

endpackage

// File: rtl/mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate a doubled request vector so the
// search starts just past the last winner, then priority-encode the lowest bit.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int CH = CH_DEF,
   localparam int SW = clog2(CH)
) (
   input  logic [CH-1:0] req,
   input  logic [SW-1:0] last,
   input  logic          en,
   output logic [CH-1:0] gnt_onehot,
   output logic [SW-1:0] gnt_idx,
   output logic          any
);

   localparam logic [SW-1:0] LAST_IDX = SW'(CH - 1);
   localparam logic [SW:0]   CH_W     = (SW + 1)'(CH);

   logic [SW-1:0]   w_start;
   logic [2*CH-1:0] w_dbl;
   logic [2*CH-1:0] w_shift;
   logic [CH-1:0]   w_rot;
   logic [SW-1:0]   w_ofs;
   logic [SW:0]     w_sum;
   logic [SW:0]     w_idx;

   // wrap at CH-1, not at 2^SW-1, so non power-of-two CH stays in range
   assign w_start = (last >= LAST_IDX) ? '0 : last + 1'b1;

   assign w_dbl   = {req, req};
   assign w_shift = w_dbl >> w_start;
   assign w_rot   = w_shift[CH-1:0];

   always_comb begin
      w_ofs = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (w_rot[i]) w_ofs = SW'(i);
      end
   end

   assign w_sum   = {1'b0, w_start} + {1'b0, w_ofs};
   assign w_idx   = (w_sum >= CH_W) ? w_sum - CH_W : w_sum;
   assign gnt_idx = w_idx[SW-1:0];
   assign any     = |req;

   always_comb begin
      gnt_onehot = '0;
      for (int i = 0; i < CH; i++) begin
         gnt_onehot[i] = en && any && (gnt_idx == SW'(i));
      end
   end

endmodule

// File: rtl/mux_rr.sv
// CH-channel valid/ready stream mux with round-robin grant and a single
// registered output slot that refills in the same cycle it drains.
module mux_rr
   import mux_pkg::*;
#(
   parameter  int n  = N_DEF,
   parameter  int CH = CH_DEF,
   localparam int SW = clog2(CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CH-1:0][n-1:0] in_data,
   input  logic [CH-1:0]        in_valid,
   output logic [CH-1:0]        in_ready,
   output logic [n-1:0]         out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SW-1:0]        out_sel
);

   localparam logic [SW-1:0] LAST_IDX = SW'(CH - 1);

   logic [n-1:0]  r_data;
   logic          r_valid;
   logic [SW-1:0] r_sel;
   logic [SW-1:0] r_last;

   logic          w_free;
   logic          w_en;
   logic          w_any;
   logic          w_xfer;
   logic [SW-1:0] w_gidx;
   logic [CH-1:0] w_gnt;

   assign w_free = !r_valid || out_ready;
   // inputs are ignored while reset is held even though the slot is free
   assign w_en   = w_free && rst_n;
   assign w_xfer = w_any && w_free;

   rr_arbiter #(
      .CH (CH)
   ) u_arb (
      .req        (in_valid),
      .last       (r_last),
      .en         (w_en),
      .gnt_onehot (w_gnt),
      .gnt_idx    (w_gidx),
      .any        (w_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_sel   <= '0;
         r_last  <= LAST_IDX;
      end else if (w_xfer) begin
         r_data  <= in_data[w_gidx];
         r_valid <= 1'b1;
         r_sel   <= w_gidx;
         r_last  <= w_gidx;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign in_ready  = w_gnt;
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign out_sel   = r_sel;

   a_ready_onehot : assert property (
      @(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

   a_hold_stable : assert property (
      @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_mux_rr.sv
// Randomised and directed checks of mux_rr against a queue-free behavioural
// model of the round-robin output slot.
module tb_mux_rr;

   logic             clk;
   logic             rst_n;
   logic [3:0][31:0] in_data;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [31:0]      out_data;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_sel;

   int n_cmp;
   int n_err;

   logic [31:0] m_data;
   logic        m_valid;
   int          m_sel;
   int          m_last;

   mux_rr #(
      .n  (32),
      .CH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sel   (out_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   function automatic int exp_grant(input logic [3:0] v, input int last);
      for (int k = 1; k <= 4; k++) begin
         int c;
         c = (last + k) % 4;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      int g;
      g = exp_grant(in_valid, m_last);
      if (rst_n && (!m_valid || out_ready) && g >= 0)
         return 4'(1 << g);
      return 4'b0000;
   endfunction

   task automatic m_reset();
      m_data  = '0;
      m_valid = 1'b0;
      m_sel   = 0;
      m_last  = 3;
   endtask

   task automatic step();
      int   g;
      logic fr;
      g  = exp_grant(in_valid, m_last);
      fr = !m_valid || out_ready;
      @(posedge clk);
      if (fr && g >= 0) begin
         m_data  = in_data[g];
         m_sel   = g;
         m_valid = 1'b1;
         m_last  = g;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) in_data[i] = 32'hA0 + 32'(i);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rst_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (out_data !== 32'h0) begin
         n_err++;
         $display("FAIL rst_data: got %h want 0", out_data);
      end
      n_cmp++;
      if (in_ready !== 4'b0000) begin
         n_err++;
         $display("FAIL rst_ready: got %b want 0000", in_ready);
      end
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL rst_first: got %b want 0001", in_ready);
      end
   endtask

   task automatic test_rotation();
      int exp_sel[5] = '{0, 1, 2, 3, 0};
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (out_sel !== 2'(exp_sel[i]) || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rot_sel[%0d]: got %0d/%b want %0d/1",
                     i, out_sel, out_valid, exp_sel[i]);
         end
         n_cmp++;
         if (out_data !== 32'hA0 + 32'(exp_sel[i])) begin
            n_err++;
            $display("FAIL rot_data[%0d]: got %h want %h",
                     i, out_data, 32'hA0 + 32'(exp_sel[i]));
         end
      end
   endtask

   task automatic test_backpressure();
      in_data[2] = 32'hDEADBEEF;
      in_valid   = 4'b0100;
      out_ready  = 1'b1;
      step();
      n_cmp++;
      if (out_data !== 32'hDEADBEEF || out_sel !== 2'd2) begin
         n_err++;
         $display("FAIL bp_load: got %h/%0d want deadbeef/2",
                  out_data, out_sel);
      end
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (in_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_ready[%0d]: got %b want 0000", i, in_ready);
         end
         step();
         n_cmp++;
         if (out_data !== 32'hDEADBEEF || out_sel !== 2'd2 ||
             out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: got %h/%0d/%b want deadbeef/2/1",
                     i, out_data, out_sel, out_valid);
         end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b1000) begin
         n_err++;
         $display("FAIL bp_next: got %b want 1000", in_ready);
      end
      step();
      n_cmp++;
      if (out_sel !== 2'd3 || out_data !== in_data[3]) begin
         n_err++;
         $display("FAIL bp_ch3: got %0d/%h want 3/%h",
                  out_sel, out_data, in_data[3]);
      end
   endtask

   task automatic test_sparse();
      int exp_sel[4] = '{3, 1, 3, 1};
      out_ready = 1'b1;
      in_valid  = 4'b0010;
      step();
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++;
         if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0 ||
             in_ready !== 4'(1 << exp_sel[i])) begin
            n_err++;
            $display("FAIL sp_ready[%0d]: got %b want %b",
                     i, in_ready, 4'(1 << exp_sel[i]));
         end
         step();
         n_cmp++;
         if (out_sel !== 2'(exp_sel[i])) begin
            n_err++;
            $display("FAIL sp_sel[%0d]: got %0d want %0d",
                     i, out_sel, exp_sel[i]);
         end
      end
   endtask

   task automatic test_simul();
      in_data[0] = 32'h12345678;
      in_valid   = 4'b0001;
      out_ready  = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL sim_pre: got %b/%b want 1/0001", out_valid, in_ready);
      end
      step();
      n_cmp++;
      if (out_data !== 32'h12345678 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL sim_load: got %h/%b want 12345678/1",
                  out_data, out_valid);
      end
      in_valid = 4'b0000;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 32'h12345678) begin
         n_err++;
         $display("FAIL sim_drain: got %h/%b want 12345678/0",
                  out_data, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      in_data[0] = 32'h55;
      in_valid   = 4'b0001;
      out_ready  = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h55) begin
         n_err++;
         $display("FAIL rm_load: got %h/%b want 55/1", out_data, out_valid);
      end
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 4'b0) begin
         n_err++;
         $display("FAIL rm_async: got %h/%b/%b want 0/0/0000",
                  out_data, out_valid, in_ready);
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL rm_first: got %b want 0001", in_ready);
      end
      step();
      n_cmp++;
      if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rm_sel: got %0d/%b want 0/1", out_sel, out_valid);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) in_data[i] = $urandom;
         in_valid  = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_cmp++;
         if (in_ready !== exp_ready()) begin
            n_err++;
            $display("FAIL rnd_ready[%0d]: got %b want %b",
                     c, in_ready, exp_ready());
         end
         step();
         n_cmp++;
         if (out_valid !== m_valid ||
             (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
            n_err++;
            $display("FAIL rnd_out[%0d]: got %b/%h/%0d want %b/%h/%0d",
                     c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_sparse();
      test_simul();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
